regbus_initiator: RTL and testbench
===================================

Name: regbus_initiator

Overview:
- Master end of the single-cycle register bus used by the clock peripherals (wr/waddr/wdata write strobe; rd/raddr read strobe; rdata returned one cycle after rd).
- Accepts read and write commands from a control FSM (UI or button logic) over a valid/ready handshake.
- Drives the bus strobes, captures read data and returns a response pulse.
- Contains an autonomous periodic poller that re-reads one peripheral register, such as the alarm status, and publishes the result.

Parameters:
- ADDRWIDTH, 4: width of the bus address.
- POLL_CYCLES, 1000: clocks between poll requests; legal range 2 to 2^20.
- POLL_ADDR, 'h04: bus address read by the poller.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  command offered.
- req_ready  out  1  command accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDRWIDTH  command address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse for a user command.
- rsp_write  out  1  type of the completed command.
- rsp_rdata  out  32  read data; 0 for writes.
- poll_en  in  1  enables the poller.
- poll_update  out  1  one-cycle pulse when poll_data is refreshed.
- poll_data  out  32  last polled value.
- wr  out  1  bus write strobe.
- waddr  out  ADDRWIDTH  bus write address.
- wdata  out  32  bus write data.
- rd  out  1  bus read strobe.
- raddr  out  ADDRWIDTH  bus read address.
- rdata  in  32  bus read data, valid the cycle after rd.

Behaviour:
- Reset values: all outputs are 0 except req_ready. req_ready = 1 once rst_n is released, because req_ready is derived as IDLE && !poll_pending. State is IDLE, the poll counter is 0, poll_pending is 0.
- All bus outputs are registered.
- waddr, wdata and raddr hold their last driven value while idle.
- State machine states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- IDLE, when poll_pending = 1:
  - the poll wins; poll_pending clears;
  - raddr is loaded with POLL_ADDR and rd goes to 1;
  - next state RD_ISSUE with the internal tag "poll".
- IDLE, else when req_valid = 1 (req_ready = 1 in this case):
  - for a write, wr goes to 1 and waddr/wdata are loaded; next state WR_ISSUE;
  - for a read, rd goes to 1 and raddr is loaded; next state RD_ISSUE with tag "user".
- WR_ISSUE (wr high for exactly 1 cycle):
  - wr goes to 0;
  - rsp_valid = 1, rsp_write = 1, rsp_rdata = 0;
  - next state IDLE.
- RD_ISSUE (rd high for exactly 1 cycle): rd goes to 0; next state RD_WAIT.
- RD_WAIT, sampling rdata:
  - for a user read: rsp_valid = 1, rsp_write = 0, rsp_rdata = rdata;
  - for a poll read: poll_data = rdata and poll_update = 1;
  - next state IDLE.
- Latency from the accepting edge to the rsp_valid-high edge:
  - 1 edge for a write, so the pulse is visible the cycle after the wr cycle;
  - 2 edges for a read.
- Throughput: one write per 2 cycles; one read per 3 cycles.
- req_ready = IDLE && !poll_pending. Only one command is ever outstanding.
- Poll timer:
  - while poll_en = 1 the counter increments every cycle regardless of the FSM;
  - at POLL_CYCLES-1 it wraps to 0 and sets poll_pending;
  - a terminal count while poll_pending is already 1 is absorbed; there is no queueing.
- poll_en = 0:
  - the counter and poll_pending clear synchronously;
  - an in-flight poll read still completes and pulses poll_update.
- poll_en rising: the first poll occurs POLL_CYCLES cycles later.
- rd and wr are never high in the same cycle.
- Reset mid-transaction: strobes drop at once, the FSM returns to IDLE, and no response is generated.

Decomposition:
- Shared package regbus_pkg:
  - state enum (IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT);
  - the peripheral address localparams (ADDR_STATUS = 'h04, ADDR_TIME = 'h08) shared with the peripherals.
- Sub-module poll_timer:
  - parameters POLL_CYCLES; inputs clk, rst_n, en, clr_pending;
  - output pending;
  - width $clog2(POLL_CYCLES).

Test Plan:
- Write then read: write 'h08 ← 'h0012_3045; rsp_valid one cycle after the wr cycle. Then read 'h08: rd high one cycle, rsp_rdata = 'h0012_3045 two edges after acceptance.
- Back-to-back: req_valid held with 3 writes, 'h04 ← 1, 2, 3. wr pulses on every other cycle; req_ready is low during WR_ISSUE; the final model register value is 3.
- Poll: POLL_CYCLES = 8, poll_en = 1, peripheral status = 'hA5. poll_update pulses every 8 cycles with poll_data = 'hA5; raddr = 'h04.
- Collision: poll_pending and req_valid rise together. The poll read is issued first, the user request is accepted at the next IDLE, and both complete with correct data.
- poll_en drop mid-read: the in-flight poll completes with a poll_update pulse; no further rd occurs while poll_en = 0.
- Reset asserted during RD_WAIT: rd = 0, rsp_valid = 0, req_ready = 1 after release, and there is no spurious poll_update.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared definitions for the clock-peripheral register bus: initiator states
// and the peripheral register map.
package regbus_pkg;

  localparam int unsigned DATA_W = 32;

  // Peripheral register addresses, shared with the peripheral blocks
  localparam int unsigned ADDR_STATUS = 'h04;
  localparam int unsigned ADDR_TIME   = 'h08;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/poll_timer.sv
// Free-running poll interval timer: raises a sticky pending flag every
// POLL_CYCLES clocks while enabled; the flag is cleared by the consumer.
module poll_timer #(
  parameter int unsigned POLL_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr_pending,
  output logic pending
);

  localparam int unsigned CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == CW'(POLL_CYCLES - 1));

  // A terminal count that lands while a poll is already pending is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      pending <= 1'b0;
    end else if (!en) begin
      r_cnt   <= '0;
      pending <= 1'b0;
    end else begin
      r_cnt   <= w_tc ? '0 : r_cnt + CW'(1);
      pending <= (pending & ~clr_pending) | w_tc;
    end
  end

endmodule

// File: rtl/regbus_initiator.sv
// Register-bus master: serialises user read/write commands and periodic
// status polls onto the single-cycle wr/rd strobe bus.
module regbus_initiator
  import regbus_pkg::*;
#(
  parameter int unsigned ADDRWIDTH   = 4,
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int unsigned POLL_ADDR   = ADDR_STATUS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [DATA_W-1:0]    rsp_rdata,
  input  logic                 poll_en,
  output logic                 poll_update,
  output logic [DATA_W-1:0]    poll_data,
  output logic                 wr,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 rd,
  output logic [ADDRWIDTH-1:0] raddr,
  input  logic [DATA_W-1:0]    rdata
);

  state_e r_state;
  logic   r_is_poll;
  logic   w_poll_pending;
  logic   w_poll_clr;

  assign req_ready  = (r_state == IDLE) && !w_poll_pending;
  assign w_poll_clr = (r_state == IDLE) && w_poll_pending;

  poll_timer #(
    .POLL_CYCLES (POLL_CYCLES)
  ) u_poll_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (poll_en),
    .clr_pending (w_poll_clr),
    .pending     (w_poll_pending)
  );

  // Command sequencer; the poll always wins over a user request in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_is_poll   <= 1'b0;
      wr          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      rd          <= 1'b0;
      raddr       <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      poll_update <= 1'b0;
      poll_data   <= '0;
    end else begin
      wr          <= 1'b0;
      rd          <= 1'b0;
      rsp_valid   <= 1'b0;
      poll_update <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_poll_pending) begin
            rd        <= 1'b1;
            raddr     <= ADDRWIDTH'(POLL_ADDR);
            r_is_poll <= 1'b1;
            r_state   <= RD_ISSUE;
          end else if (req_valid) begin
            if (req_write) begin
              wr      <= 1'b1;
              waddr   <= req_addr;
              wdata   <= req_wdata;
              r_state <= WR_ISSUE;
            end else begin
              rd        <= 1'b1;
              raddr     <= req_addr;
              r_is_poll <= 1'b0;
              r_state   <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: begin
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          r_state   <= IDLE;
        end
        RD_ISSUE: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Peripheral returns rdata the cycle after the rd strobe
          if (r_is_poll) begin
            poll_data   <= rdata;
            poll_update <= 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= rdata;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_initiator.sv
// Directed bench for regbus_initiator with a register-file peripheral model
// and a response scoreboard.
module tb_regbus_initiator;

  localparam int unsigned AW = 4;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic          poll_en;
  logic          poll_update;
  logic [31:0]   poll_data;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          rd;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;

  int   vectors;
  int   miscompares;
  int   since_en;
  exp_t sb[$];
  logic [31:0] model_mem [16];
  logic [31:0] pmem [16];

  regbus_initiator #(
    .ADDRWIDTH   (AW),
    .POLL_CYCLES (8),
    .POLL_ADDR   ('h04)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .poll_en     (poll_en),
    .poll_update (poll_update),
    .poll_data   (poll_data),
    .wr          (wr),
    .waddr       (waddr),
    .wdata       (wdata),
    .rd          (rd),
    .raddr       (raddr),
    .rdata       (rdata)
  );

  always #5 clk = ~clk;

  // Peripheral register file: write on wr, registered read data after rd
  always @(posedge clk) begin
    if (wr) pmem[waddr] <= wdata;
    if (rd) rdata <= pmem[raddr];
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and bus protocol monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check1("rd_wr_exclusive", rd && wr, 1'b0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check1("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check1("sb_rsp_write", rsp_write, e.w);
          check32("sb_rsp_rdata", rsp_rdata, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    since_en++;
  endtask

  task automatic tick_to(input int k);
    while (since_en < k) tick();
  endtask

  task automatic expect_rsp(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    exp_t e;
    if (w) begin
      model_mem[a] = d;
      e = {1'b1, 32'h0};
    end else begin
      e = {1'b0, model_mem[a]};
    end
    sb.push_back(e);
  endtask

  // Full command with bounded waits for acceptance and completion
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input string tag);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check1({tag, "_accept"}, req_ready, 1'b1);
    expect_rsp(w, a, d);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check1({tag, "_rsp"}, rsp_valid, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    poll_en = 1'b0;
    vectors = 0; miscompares = 0; since_en = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reset values
    repeat (3) tick();
    check1("rst_wr", wr, 1'b0);
    check1("rst_rd", rd, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_poll_update", poll_update, 1'b0);
    check32("rst_poll_data", poll_data, 32'h0);
    check32("rst_raddr", 32'(raddr), 32'h0);
    rst_n = 1'b1;
    tick();
    check1("rst_req_ready", req_ready, 1'b1);

    // Write 'h08 <- 'h0012_3045
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h8; req_wdata = 32'h0012_3045;
    check1("wr_ready", req_ready, 1'b1);
    expect_rsp(1'b1, 4'h8, 32'h0012_3045);
    tick();
    req_valid = 1'b0;
    check1("wr_strobe", wr, 1'b1);
    check32("wr_waddr", 32'(waddr), 32'h8);
    check32("wr_wdata", wdata, 32'h0012_3045);
    check1("wr_ready_busy", req_ready, 1'b0);
    check1("wr_no_early_rsp", rsp_valid, 1'b0);
    tick();
    check1("wr_strobe_drop", wr, 1'b0);
    check1("wr_rsp_valid", rsp_valid, 1'b1);
    check1("wr_rsp_write", rsp_write, 1'b1);
    check32("wr_rsp_rdata", rsp_rdata, 32'h0);
    check1("wr_ready_back", req_ready, 1'b1);
    tick();

    // Read 'h08 back
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8;
    expect_rsp(1'b0, 4'h8, 32'h0);
    tick();
    req_valid = 1'b0;
    check1("rd_strobe", rd, 1'b1);
    check32("rd_raddr", 32'(raddr), 32'h8);
    check1("rd_no_wr", wr, 1'b0);
    tick();
    check1("rd_strobe_drop", rd, 1'b0);
    check1("rd_no_early_rsp", rsp_valid, 1'b0);
    check32("wdata_held", wdata, 32'h0012_3045);
    tick();
    check1("rd_rsp_valid", rsp_valid, 1'b1);
    check1("rd_rsp_write", rsp_write, 1'b0);
    check32("rd_rsp_rdata", rsp_rdata, 32'h0012_3045);
    tick();

    // Back-to-back writes with req_valid held
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h4;
    for (int i = 1; i <= 3; i++) begin
      req_wdata = 32'(i);
      check1("b2b_ready", req_ready, 1'b1);
      expect_rsp(1'b1, 4'h4, 32'(i));
      tick();
      check1("b2b_wr", wr, 1'b1);
      check32("b2b_wdata", wdata, 32'(i));
      check1("b2b_ready_low", req_ready, 1'b0);
      tick();
      check1("b2b_wr_gap", wr, 1'b0);
      check1("b2b_rsp", rsp_valid, 1'b1);
    end
    req_valid = 1'b0;
    tick();
    do_cmd(1'b0, 4'h4, 32'h0, "b2b_readback");

    // Poll: status = 'hA5, poll every 8 cycles
    do_cmd(1'b1, 4'h4, 32'hA5, "status_wr");
    poll_en = 1'b1;
    since_en = 0;
    for (int k = 1; k <= 28; k++) begin
      tick();
      check1("poll_update_timing", poll_update, (k == 11) || (k == 19) || (k == 27));
      if (k == 9 || k == 17) begin
        check1("poll_rd", rd, 1'b1);
        check32("poll_raddr", 32'(raddr), 32'h4);
      end
      if (k == 11) check32("poll_data", poll_data, 32'hA5);
    end

    // Collision: user read offered in the cycle poll_pending rises
    tick_to(32);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8;
    check1("coll_ready_low", req_ready, 1'b0);
    expect_rsp(1'b0, 4'h8, 32'h0);
    tick();
    check1("coll_poll_first", rd, 1'b1);
    check32("coll_poll_raddr", 32'(raddr), 32'h4);
    tick();
    tick();
    check1("coll_poll_update", poll_update, 1'b1);
    check1("coll_ready_after", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check1("coll_user_rd", rd, 1'b1);
    check32("coll_user_raddr", 32'(raddr), 32'h8);
    tick();
    tick();
    check1("coll_user_rsp", rsp_valid, 1'b1);
    check32("coll_user_rdata", rsp_rdata, 32'h0012_3045);

    // poll_en drop while a poll read is in flight
    tick_to(41);
    check1("drop_poll_rd", rd, 1'b1);
    poll_en = 1'b0;
    tick();
    tick();
    check1("drop_poll_update", poll_update, 1'b1);
    check32("drop_poll_data", poll_data, 32'hA5);
    for (int k = 0; k < 20; k++) begin
      tick();
      check1("drop_no_rd", rd, 1'b0);
    end

    // Reset asserted in RD_WAIT of a user read: no response afterwards
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8;
    tick();
    req_valid = 1'b0;
    check1("rstmid_rd", rd, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check1("rstmid_rd_drop", rd, 1'b0);
    check1("rstmid_rsp_valid", rsp_valid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check1("rstmid_ready", req_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check1("rstmid_no_rsp", rsp_valid, 1'b0);
      check1("rstmid_no_poll", poll_update, 1'b0);
    end

    check32("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
